// File: rtl/puf_resp_serializer.sv
// Captures the RO PUF response a fixed settle time after start falls and streams
// {challenge, response bytes LSB first} over valid/ready. `RESP_HW_EN appends a 16-bit Hamming weight.
module puf_resp_serializer #(
  parameter int SETTLE_CYCLES = 16,
  parameter int RESP_W        = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        challenge,
  input  logic [RESP_W-1:0] response,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy,
  output logic              overrun
);

  localparam int NB = RESP_W / 8;
`ifdef RESP_HW_EN
  localparam int NFRAME = NB + 3;
`else
  localparam int NFRAME = NB + 1;
`endif
  localparam int IDXW = $clog2(NFRAME + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFRAME - 1);
  localparam logic [7:0]      CNT_END  = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_LOW, SETTLE, SEND} state_t;

  state_t            state, state_nx;
  logic              start_q, rise, xfer, capture;
  logic [7:0]        chal_r, cnt;
  logic [NB-1:0][7:0] resp_r;
  logic [IDXW-1:0]   idx;

  assign rise    = start & ~start_q;
  assign xfer    = tx_valid & tx_ready;
  assign capture = (state == SETTLE) && (cnt == CNT_END);

`ifdef RESP_HW_EN
  localparam int HWW = $clog2(RESP_W + 1);
  logic [RESP_W-1:0] resp_flat;
  logic [HWW-1:0]    hw;
  logic [15:0]       hw16;

  // resp_r is stable for the whole SEND state, so a combinational popcount
  // is settled before the first byte goes out and needs no extra wait state.
  assign resp_flat = resp_r;
  always_comb begin
    hw = '0;
    for (int i = 0; i < RESP_W; i++) hw = hw + HWW'(resp_flat[i]);
    hw16 = 16'(hw);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    tx_data  = '0;
    busy     = (state != IDLE);
    case (state)
      IDLE:     if (rise)    state_nx = WAIT_LOW;
      WAIT_LOW: if (!start)  state_nx = SETTLE;
      SETTLE:   if (capture) state_nx = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_last  = (idx == LAST_IDX);
        if (idx == '0) tx_data = chal_r;
        for (int k = 0; k < NB; k++)
          if (idx == IDXW'(k + 1)) tx_data = resp_r[k];
`ifdef RESP_HW_EN
        if (idx == IDXW'(NB + 1)) tx_data = hw16[15:8];
        if (idx == IDXW'(NB + 2)) tx_data = hw16[7:0];
`endif
        if (xfer && tx_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Edges outside IDLE are dropped; overrun flags them one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q <= 1'b0;
      overrun <= 1'b0;
      chal_r  <= '0;
      cnt     <= '0;
      resp_r  <= '0;
      idx     <= '0;
    end else begin
      start_q <= start;
      overrun <= rise && (state != IDLE);
      if (state == IDLE && rise) chal_r <= challenge;
      if (state == WAIT_LOW && !start) cnt <= '0;
      else if (state == SETTLE)        cnt <= cnt + 8'd1;
      if (capture) begin
        resp_r <= response;
        idx    <= '0;
      end else if (xfer) begin
        idx <= idx + IDXW'(1);
      end
    end
  end

endmodule

// File: tb/tb_puf_resp_serializer.sv
// Randomized scoreboard bench for puf_resp_serializer; honours `RESP_HW_EN for frame layout.
module tb_puf_resp_serializer;
  localparam int S  = 4;
  localparam int RW = 256;
  localparam int NB = RW / 8;
`ifdef RESP_HW_EN
  localparam bit HW = 1'b1;
`else
  localparam bit HW = 1'b0;
`endif
  localparam int FL = NB + 1 + (HW ? 2 : 0);

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, tx_ready = 1'b0;
  logic [7:0]    challenge = '0;
  logic [RW-1:0] response = '0;
  logic [7:0]    tx_data;
  logic          tx_valid, tx_last, busy, overrun;

  puf_resp_serializer #(.SETTLE_CYCLES(S), .RESP_W(RW)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .response(response),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  logic [8:0] exp_q[$];   // {last, data}
  int n_cmp = 0, n_err = 0, ovr_cnt = 0, frame_xfers = 0, tot_xfers = 0;
  int rdy_mode = 0, rdy_ph = 0;
  bit chk_idle = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // tx_ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: tx_ready = 1'b1;
      1: begin tx_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3); rdy_ph++; end
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every presented byte is compared to the queue head, so stalls also check hold.
  always @(negedge clk) begin
    if (overrun) ovr_cnt++;
    if (!rst) begin
      if (chk_idle) begin
        check("idle_after_last", {30'd0, busy, tx_valid}, 32'd0);
        chk_idle = 1'b0;
      end
      if (tx_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got %0h with no byte expected", tx_data);
        end else begin
          check("tx_data", {24'd0, tx_data}, {24'd0, exp_q[0][7:0]});
          check("tx_last", {31'd0, tx_last}, {31'd0, exp_q[0][8]});
          if (tx_ready) begin
            tot_xfers++;
            if (exp_q[0][8]) begin chk_idle = 1'b1; frame_xfers = 0; end
            else frame_xfers++;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_frame(input logic [7:0] ch, input logic [RW-1:0] r);
    int   hw;
    logic l;
    exp_q.push_back({1'b0, ch});
    for (int k = 1; k <= NB; k++) begin
      l = (k == NB) && !HW;
      exp_q.push_back({l, 8'(r >> (8 * (k - 1)))});
    end
    if (HW) begin
      hw = $countones(r);
      exp_q.push_back({1'b0, 8'(hw >> 8)});
      exp_q.push_back({1'b1, 8'(hw)});
    end
  endtask

  // Returns just after the capture edge. glitch: only the cycle before capture carries r.
  task automatic start_frame(input logic [7:0] ch, input logic [RW-1:0] r, input int hi, input bit glitch);
    push_frame(ch, r);
    challenge = ch;
    start     = 1'b1;
    response  = glitch ? {NB{8'hAA}} : r;
    repeat (hi) tick();
    start     = 1'b0;
    challenge = 8'($urandom);
    if (glitch) begin
      repeat (S) tick();
      response = r;
      tick();
      response = {NB{8'hAA}};
    end else begin
      repeat (S + 1) tick();
      response = {8{$urandom}};
    end
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin tick(); n++; end
    if (n >= 3000) begin
      n_cmp++; n_err++;
      $display("FAIL timeout_%s: %0d bytes outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run(input string tag, input logic [7:0] ch, input logic [RW-1:0] r,
                     input int hi, input bit glitch);
    int x0 = tot_xfers;
    start_frame(ch, r, hi, glitch);
    wait_idle(tag);
    check({"len_", tag}, tot_xfers - x0, FL);
  endtask

  logic [RW-1:0] base_resp;
  int o0, n;

  initial begin
    base_resp = 256'h0807_0605_0403_0201;
    repeat (3) tick();
    check("rst_tx_valid", {31'd0, tx_valid}, 0);
    check("rst_tx_last",  {31'd0, tx_last},  0);
    check("rst_busy",     {31'd0, busy},     0);
    check("rst_overrun",  {31'd0, overrun},  0);
    check("rst_tx_data",  {24'd0, tx_data},  0);
    rst = 1'b0;
    tick();
    check("post_rst_busy", {31'd0, busy}, 0);

    rdy_mode = 0; run("basic", 8'h3C, base_resp, 3, 1'b0);
    rdy_mode = 1; rdy_ph = 0; run("bp", 8'h3C, base_resp, 3, 1'b0);
    rdy_mode = 0; run("settle", 8'h77, {NB{8'h55}}, 2, 1'b1);

    // overrun during SEND
    rdy_mode = 1; rdy_ph = 0; o0 = ovr_cnt;
    start_frame(8'h3C, base_resp, 3, 1'b0);
    repeat (3) tick();
    challenge = 8'hA5; start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("overrun_send", ovr_cnt - o0, 1);
    wait_idle("ovr");
    repeat (40) tick();
    check("ovr_no_2nd_frame", {31'd0, busy}, 0);

    // rising edge coincident with final transfer
    rdy_mode = 0; o0 = ovr_cnt;
    start_frame(8'h3C, base_resp, 1, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(tx_valid && tx_last) && n < 200);
    if (n >= 200) begin n_cmp++; n_err++; $display("FAIL timeout_last: no final byte, expected one"); end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) tick();
    check("overrun_last", ovr_cnt - o0, 1);
    wait_idle("ovr_last");
    repeat (40) tick();
    check("last_no_2nd_frame", {31'd0, busy}, 0);

    // reset mid-frame
    rdy_mode = 0;
    start_frame(8'h3C, base_resp, 2, 1'b0);
    n = 0;
    while (frame_xfers < 10 && n < 500) begin @(posedge clk); n++; end
    #2 rst = 1'b1;
    #1;
    check("arst_tx_valid", {31'd0, tx_valid}, 0);
    check("arst_busy",     {31'd0, busy},     0);
    check("arst_tx_last",  {31'd0, tx_last},  0);
    exp_q.delete(); frame_xfers = 0; chk_idle = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_arst_idle", {31'd0, busy}, 0);
    run("after_rst", 8'h3C, base_resp, 3, 1'b0);

    run("ones", 8'hC3, {RW{1'b1}}, 2, 1'b0);
    run("one",  8'h1E, 256'h1, 1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rdy_mode = $urandom_range(0, 2);
      rdy_ph   = 0;
      run("rand", 8'($urandom), {8{$urandom}}, $urandom_range(1, 4), 1'b0);
    end

    check("total_overruns", ovr_cnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
